// File: rtl/tx_msg_sender.sv
// Walks the transmit ROM from address 0 to the last word and sends each word as a
// start bit, DATA_WIDTH data bits (LSB first) and one stop bit on the tx line.
module tx_msg_sender #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_read,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0]     BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]     BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]      BIT_MAX   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]      BIT_ONE   = BIT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_index, w_index;
  logic [BAUD_W-1:0]     r_baud, w_baud;
  logic [BIT_W-1:0]      r_bit, w_bit;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic                  r_tx, w_tx;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_rom_read, w_rom_read;
  logic [ADDR_WIDTH-1:0] r_rom_addr, w_rom_addr;
  logic                  w_baud_wrap;

  assign w_baud_wrap = (r_baud == BAUD_MAX);

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rom_read <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_state    <= w_state;
      r_index    <= w_index;
      r_baud     <= w_baud;
      r_bit      <= w_bit;
      r_shift    <= w_shift;
      r_tx       <= w_tx;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_rom_read <= w_rom_read;
      r_rom_addr <= w_rom_addr;
    end
  end

  // Next-state and next-output logic; tx is computed one cycle ahead so it is registered.
  always_comb begin
    w_state    = r_state;
    w_index    = r_index;
    w_baud     = r_baud;
    w_bit      = r_bit;
    w_shift    = r_shift;
    w_tx       = r_tx;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_rom_read = 1'b0;
    w_rom_addr = r_rom_addr;
    case (r_state)
      S_IDLE: begin
        w_tx       = 1'b1;
        w_index    = '0;
        w_rom_addr = '0;
        if (start) begin
          w_state    = S_FETCH;
          w_busy     = 1'b1;
          w_rom_read = 1'b1;
        end else begin
          w_state    = S_IDLE;
          w_busy     = 1'b0;
        end
      end
      S_FETCH: begin
        w_state = S_LOAD;
      end
      S_LOAD: begin
        w_shift = rom_q;
        w_baud  = '0;
        w_tx    = 1'b0;
        w_state = S_START;
      end
      S_START: begin
        if (w_baud_wrap) begin
          w_baud  = '0;
          w_bit   = '0;
          w_tx    = r_shift[0];
          w_state = S_DATA;
        end else begin
          w_baud  = r_baud + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_baud_wrap) begin
          w_baud = '0;
          if (r_bit == BIT_MAX) begin
            w_tx    = 1'b1;
            w_state = S_STOP;
          end else begin
            w_shift = {1'b0, r_shift[DATA_WIDTH-1:1]};
            w_tx    = r_shift[1];
            w_bit   = r_bit + BIT_ONE;
          end
        end else begin
          w_baud = r_baud + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_baud_wrap) begin
          w_baud = '0;
          if (r_index == IDX_LAST) begin
            w_state    = S_IDLE;
            w_busy     = 1'b0;
            w_done     = 1'b1;
            w_index    = '0;
            w_rom_addr = '0;
          end else begin
            w_state    = S_FETCH;
            w_index    = r_index + IDX_ONE;
            w_rom_addr = r_index + IDX_ONE;
            w_rom_read = 1'b1;
          end
        end else begin
          w_baud = r_baud + BAUD_ONE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign rom_addr = r_rom_addr;
  assign rom_read = r_rom_read;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_tx_msg_sender.sv
// Directed bench for tx_msg_sender with CLKS_PER_BIT=4 and a 4-word ROM model.
module tb_tx_msg_sender;

  localparam int CPB  = 4;
  localparam int WORD = 2 + 10 * CPB;   // 42 cycles per word
  localparam int MSG  = 4 * WORD;       // 168 cycles per message

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] rom_addr;
  logic       rom_read;
  logic [7:0] rom_q;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] msg [4];
  logic       tx_log [400];
  logic       rr_log [400];
  logic       done_log [400];
  logic       busy_log [400];
  int         addr_log [400];

  int passed = 0;
  int total  = 0;

  tx_msg_sender #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_read(rom_read), .rom_q(rom_q), .tx(tx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered ROM: data appears the cycle after rom_read
  always @(posedge clk) begin
    if (rom_read) rom_q <= msg[rom_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // log[k] holds outputs just after edge E(k); E0 is the edge that samples the first start
  task automatic capture(input int n, input bit hold, input int p1, input int p2);
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      tx_log[k]   = tx;
      rr_log[k]   = rom_read;
      done_log[k] = done;
      busy_log[k] = busy;
      addr_log[k] = int'(rom_addr);
      start = hold | (k + 1 == p1) | (k + 1 == p2);
    end
    start = 1'b0;
  endtask

  function automatic logic exp_tx(int k);
    int off, w, j;
    if (k < 2 || k >= MSG) return 1'b1;
    off = (k - 2) % WORD;
    w   = (k - 2) / WORD;
    if (off >= 10 * CPB) return 1'b1;
    j = off / CPB;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return msg[w][j-1];
  endfunction

  function automatic int decode(int base, int w);
    logic [7:0] b;
    for (int j = 1; j <= 8; j++) b[j-1] = tx_log[base + 2 + WORD * w + CPB * j + 2];
    return int'(b);
  endfunction

  function automatic int count_ones_rr(int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(rr_log[k]);
    return c;
  endfunction

  function automatic int count_ones_done(int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(done_log[k]);
    return c;
  endfunction

  function automatic int count_ones_busy(int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(busy_log[k]);
    return c;
  endfunction

  initial begin
    int bad;
    int bits_first [8];
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h21; msg[3] = 8'h0A;
    bits_first[0] = 0; bits_first[1] = 0; bits_first[2] = 0; bits_first[3] = 1;
    bits_first[4] = 0; bits_first[5] = 0; bits_first[6] = 1; bits_first[7] = 0;
    rst_n = 1'b0;
    start = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rom_read", int'(rom_read), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rom_read !== 1'b0 || rom_addr !== 2'd0) bad++;
    end
    check("post_reset_quiet", bad, 0);

    // single message
    capture(180, 1'b0, -1, -1);
    check("single_rr_count", count_ones_rr(180), 4);
    for (int w = 0; w < 4; w++) begin
      check("single_rr_at_word", int'(rr_log[WORD * w]), 1);
      check("single_addr", addr_log[WORD * w], w);
      check("single_byte", decode(0, w), int'(msg[w]));
    end
    check("single_done_count", count_ones_done(180), 1);
    check("single_done_at_168", int'(done_log[MSG]), 1);
    check("single_busy_len", count_ones_busy(180), MSG);
    check("single_busy_last", int'(busy_log[MSG-1]), 1);
    check("single_busy_fall", int'(busy_log[MSG]), 0);
    bad = 0;
    for (int k = 0; k < 180; k++) if (tx_log[k] !== exp_tx(k)) bad++;
    check("single_tx_wave", bad, 0);

    // bit order of the first frame
    bad = 0;
    for (int k = 2; k < 6; k++) if (tx_log[k] !== 1'b0) bad++;
    check("first_start_low", bad, 0);
    for (int j = 0; j < 8; j++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) if (int'(tx_log[6 + CPB * j + c]) != bits_first[j]) bad++;
      check("first_bit", bad, 0);
    end
    bad = 0;
    for (int k = 38; k < 42; k++) if (tx_log[k] !== 1'b1) bad++;
    check("first_stop_high", bad, 0);

    // start while busy
    repeat (3) tick();
    capture(180, 1'b0, 50, 100);
    check("busy_start_rr_count", count_ones_rr(180), 4);
    check("busy_start_done_count", count_ones_done(180), 1);
    check("busy_start_done_at_168", int'(done_log[MSG]), 1);

    // back-to-back
    repeat (3) tick();
    capture(2 * MSG + 2, 1'b1, -1, -1);
    check("b2b_rr_count", count_ones_rr(2 * MSG + 2), 8);
    check("b2b_done_first", int'(done_log[MSG]), 1);
    check("b2b_rr_after_done", int'(rr_log[MSG + 1]), 1);
    check("b2b_addr_after_done", addr_log[MSG + 1], 0);
    check("b2b_done_second", int'(done_log[2 * MSG + 1]), 1);
    for (int w = 0; w < 4; w++) begin
      check("b2b_byte_msg1", decode(0, w), int'(msg[w]));
      check("b2b_byte_msg2", decode(MSG + 1, w), int'(msg[w]));
    end
    bad = 0;
    for (int k = 0; k < 2 * MSG + 2; k++)
      if (tx_log[k] !== exp_tx((k > MSG) ? k - MSG - 1 : k)) bad++;
    check("b2b_tx_wave", bad, 0);

    // reset in the middle of the second word's data bits
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (59) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_rom_read", int'(rom_read), 0);
    check("midrst_rom_addr", int'(rom_addr), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || rom_read !== 1'b0) bad++;
    end
    check("midrst_no_resume", bad, 0);
    capture(50, 1'b0, -1, -1);
    check("restart_rr", int'(rr_log[0]), 1);
    check("restart_addr", addr_log[0], 0);
    check("restart_byte", decode(0, 0), 8'h48);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tx_msg_sender.md
# tx_msg_sender

Sequencer and serializer directly downstream of the transmit ROM. On a start request it walks every ROM address from 0 upward, issues one registered ROM read per word, and shifts each returned word onto the serial line as an asynchronous frame: start bit, data LSB first, one stop bit. It drives the ROM address/read inputs, consumes the ROM data output, and owns the transceiver's serial TX pin.

## Interface
- DATA_WIDTH, 8, width of each ROM word and of the frame data field.
- ADDR_WIDTH, 2, ROM address width; the message length is 2**ADDR_WIDTH words.
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  level-sampled request; accepted only in IDLE.
- rom_addr  out  ADDR_WIDTH  ROM address; equals the current word index.
- rom_read  out  1  ROM read enable; high for exactly one cycle per word.
- rom_q  in  DATA_WIDTH  ROM registered data; valid the cycle after rom_read.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a message is in progress.
- done  out  1  one-cycle pulse after the last stop bit.

## Operation
- All outputs are registered. Reset values: tx=1, busy=0, done=0, rom_read=0, rom_addr=0.
- Internal state: the FSM, the word index (ADDR_WIDTH bits), a baud counter ($clog2(CLKS_PER_BIT) bits, 0..CLKS_PER_BIT-1), a bit counter ($clog2(DATA_WIDTH) bits) and a DATA_WIDTH-bit shift register.
- IDLE: tx=1, busy=0, index=0.
  - If start=1, go to FETCH and set busy=1.
- FETCH (1 cycle): rom_read=1 and rom_addr=index.
  - The ROM captures rom_q on the edge that ends FETCH.
  - Go to LOAD.
- LOAD (1 cycle): the shift register takes rom_q on the edge that ends LOAD.
  - Go to START with baud counter=0.
- START: tx=0 for CLKS_PER_BIT cycles.
  - Go to DATA with bit counter=0.
- DATA: tx=shift[0].
  - Each time the baud counter wraps, shift right and increment the bit counter.
  - After DATA_WIDTH bits, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then:
  - if index == 2**ADDR_WIDTH-1: go to IDLE, busy=0, done=1 for one cycle;
  - otherwise: index+1 and go to FETCH.
- The index never wraps mid-message; it returns to 0 only in IDLE.
- start while busy=1 is ignored; no queuing.
- done is asserted during the first IDLE cycle. If start=1 in that cycle, a new message launches, so start held high sends the message back to back.
- Reset assertion at any point takes effect immediately without waiting for clk:
  - tx goes high and all outputs take their reset values;
  - the partial frame is abandoned and nothing resumes after reset release.

## Timing
- Edge E0 samples start=1 in IDLE. rom_read is high for the cycle after E0. tx falls at E2.
- Per word: 2 + (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
  - This includes a 2-cycle idle-high gap (FETCH and LOAD) between a stop bit and the next start bit.
- Whole message: 2**ADDR_WIDTH * (2 + (DATA_WIDTH+2)*CLKS_PER_BIT) cycles from E0 to the edge that asserts done.
- busy rises at E0 and falls on the same edge that raises done.
- Bit boundaries are exact multiples of CLKS_PER_BIT from the fall of the start bit; there is no drift between words.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_WIDTH=8, ADDR_WIDTH=2, ROM = 48,69,21,0A.
- Reset: hold rst_n=0 for 3 cycles -> tx=1, busy=0, done=0, rom_read=0, rom_addr=0. Release with start=0 -> outputs unchanged for 20 cycles.
- Single message: pulse start for 1 cycle.
  - rom_read pulses exactly 4 times, with rom_addr=0,1,2,3.
  - tx decodes to 0x48,0x69,0x21,0x0A, each frame 40 cycles long with 2-cycle gaps.
  - done pulses once, 168 cycles after E0; busy is high for exactly those 168 cycles.
- Bit order: decode the first frame -> low for 4 cycles, then bits 0,0,0,1,0,0,1,0 in 4-cycle steps, then high for 4 cycles.
- Start while busy: pulse start again at cycle 50 and at cycle 100 -> no extra rom_read, done pulses only once at cycle 168.
- Back-to-back: hold start=1 continuously -> the second message's rom_read for address 0 occurs the cycle after done, and the 8 frames decode to 48,69,21,0A repeated twice.
- Reset mid-frame: assert rst_n=0 during the second word's DATA phase.
  - tx=1 and busy=0 immediately.
  - After release and a new start, transmission restarts at address 0 with 0x48.
